keypad_input: RTL and testbench
===============================

KEYPAD_INPUT -- requirements
Module: keypad_input

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 8, meaning clk_o cycles a level must stay stable to count as press or release.
REQ-002 Parameter ROW_SETTLE, default 3, meaning clk_o cycles each scan row is driven before its columns are sampled.
REQ-003 clk_o  input  1  scan clock (divided clock, same domain as display mux); all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 row_n  output  4  keypad row drive, one-hot active-low.
REQ-006 col_n  input  4  keypad column sense, active-low, asynchronous, externally pulled up.
REQ-007 confirm_btn  input  1  raw "enter" push-button, active-high, asynchronous.
REQ-008 entry  output  32  live hex entry register, for display.
REQ-009 value  output  32  latched committed value.
REQ-010 value_valid  output  1  high while value is unconsumed.
REQ-011 value_ack  input  1  consumer acknowledge; clears value_valid.
REQ-012 key_code  output  4  last accepted key, hex 0-F.
REQ-013 key_stb  output  1  one-cycle pulse per accepted key press.

Function
REQ-014 col_n and confirm_btn SHALL each pass through a 2-flop synchronizer before any use.
REQ-015 The key FSM SHALL have states SCAN, DEBOUNCE, ACCEPT, RELEASE.
REQ-016 SCAN: drive row r low for ROW_SETTLE cycles, sample synchronized columns on the last cycle, advance r 0->1->2->3->0.
REQ-017 A sample in SCAN with any column low SHALL latch (r, c), c = lowest low column index, and go to DEBOUNCE with row r held.
REQ-018 DEBOUNCE: count stable cycles with the same (r, c); on DEBOUNCE_CYCLES go to ACCEPT; on mismatch or all-high return to SCAN at row r+1.
REQ-019 ACCEPT lasts exactly one cycle: key_code = 4*r + c, key_stb = 1, entry = {entry[27:0], key_code}, then go to RELEASE.
REQ-020 Entry shift wraps: the top nibble is discarded with no saturation and no error.
REQ-021 RELEASE: hold row r; after DEBOUNCE_CYCLES consecutive all-high samples, go to SCAN at row r+1; presses of other keys are ignored until then.
REQ-022 confirm_btn SHALL be debounced over DEBOUNCE_CYCLES; a debounced rising edge is a commit event.
REQ-023 Commit: value = entry, value_valid = 1, entry = 0, all on the same cycle.
REQ-024 A commit while value_valid = 1 SHALL be dropped; value and entry are unchanged.
REQ-025 value_ack is sampled only while value_valid = 1; value_valid clears the next cycle; value is retained.
REQ-026 Commit and ack on the same cycle: the ack clears the old value first, so the commit succeeds and value_valid stays 1 with the new value.
REQ-027 A commit on the same cycle as ACCEPT: the shifted entry including the new key is committed, and entry becomes 0.
REQ-028 Keys continue to shift into entry while value_valid = 1.

Reset
REQ-029 On rst = 0 at a clk_o edge: FSM = SCAN, r = 0, row_n = 4'b1110, entry = 0, value = 0, value_valid = 0, key_code = 0, key_stb = 0, all counters and synchronizers cleared (synchronizers to the inactive level).
REQ-030 Reset mid-press SHALL discard the pending key with no key_stb; the held key is re-detected after reset as a new press.

Structure
REQ-031 Shared package keypad_pkg SHALL hold the FSM state enum, the one-hot row drive constants and the default parameter values.
REQ-032 One sub-module, btn_debounce (synchronizer + stable counter + rising-edge pulse), SHALL be used for confirm_btn.
REQ-033 The scan FSM SHALL stay in keypad_input; target 150-300 lines total.

Verification
REQ-034 Press key at row 2, col 1 for 20 cycles after reset -> one key_stb, key_code = 9, entry = 0x00000009.
REQ-035 Press 1,2,...,9 in sequence, each released -> entry = 0x23456789 (digit 1 wrapped out).
REQ-036 Key bouncing for 5 cycles (DEBOUNCE_CYCLES = 8) -> no key_stb; FSM returns to SCAN.
REQ-037 entry = 0xABCD, confirm pressed -> value = 0x0000ABCD, value_valid = 1, entry = 0; second confirm before ack -> dropped.
REQ-038 value_ack coincident with a new commit of 0x5 -> value = 0x5, value_valid stays 1.
REQ-039 Hold key 7, pulse rst low for one cycle mid-DEBOUNCE -> row_n = 1110 and no key_stb until the key is re-detected.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner and its confirm button.
package keypad_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 8;
  localparam int ROW_SETTLE_DEF      = 3;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_ACCEPT   = 2'd2,
    ST_RELEASE  = 2'd3
  } key_state_t;

  localparam logic [3:0] ROW_DRIVE_0 = 4'b1110;
  localparam logic [3:0] ROW_DRIVE_1 = 4'b1101;
  localparam logic [3:0] ROW_DRIVE_2 = 4'b1011;
  localparam logic [3:0] ROW_DRIVE_3 = 4'b0111;

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    case (r)
      2'd0:    return ROW_DRIVE_0;
      2'd1:    return ROW_DRIVE_1;
      2'd2:    return ROW_DRIVE_2;
      default: return ROW_DRIVE_3;
    endcase
  endfunction

  // Lowest-index active-low column wins when several read low at once.
  function automatic logic [1:0] lowest_low_col(input logic [3:0] cols_n);
    if (!cols_n[0])      return 2'd0;
    else if (!cols_n[1]) return 2'd1;
    else if (!cols_n[2]) return 2'd2;
    else                 return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_input_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level counter and a
// one-cycle pulse on each debounced rising edge.
module btn_debounce
  import keypad_pkg::*;
#(
  parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_o,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          level;
  logic [CW-1:0] cnt;

  // The level only flips after the synchronized input has disagreed with it
  // for CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk_o) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      rise    <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      rise    <= 1'b0;
      if (sync_q2 != level) begin
        if (cnt == CW'(CYCLES - 1)) begin
          level <= sync_q2;
          cnt   <= '0;
          rise  <= sync_q2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/keypad_input.sv
// 4x4 hex keypad scanner with debounced key entry, a shifting hex entry
// register and a confirm button that commits the entry to a held value.
module keypad_input
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int ROW_SETTLE      = ROW_SETTLE_DEF
) (
  input  logic        clk_o,
  input  logic        rst,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  input  logic        confirm_btn,
  output logic [31:0] entry,
  output logic [31:0] value,
  output logic        value_valid,
  input  logic        value_ack,
  output logic [3:0]  key_code,
  output logic        key_stb,
  output logic [1:0]  state_dbg
);

  localparam int SW = $clog2(ROW_SETTLE + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  key_state_t    state;
  key_state_t    state_nxt;
  logic [3:0]    col_sync1;
  logic [3:0]    col_sync2;
  logic [1:0]    row_idx;
  logic [1:0]    key_col;
  logic [SW-1:0] settle_cnt;
  logic [DW-1:0] stable_cnt;

  logic          any_low;
  logic [1:0]    hit_col;
  logic          sample_now;
  logic          same_key;
  logic          stable_full;

  always_ff @(posedge clk_o) begin
    if (!rst) begin
      col_sync1 <= 4'hF;
      col_sync2 <= 4'hF;
    end else begin
      col_sync1 <= col_n;
      col_sync2 <= col_sync1;
    end
  end

  always_comb begin
    any_low     = ~&col_sync2;
    hit_col     = lowest_low_col(col_sync2);
    sample_now  = (settle_cnt == SW'(ROW_SETTLE - 1));
    same_key    = any_low && (hit_col == key_col);
    stable_full = (stable_cnt == DW'(DEBOUNCE_CYCLES - 1));
  end

  always_ff @(posedge clk_o) begin
    if (!rst) begin
      state <= ST_SCAN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_SCAN: begin
        if (sample_now && any_low) state_nxt = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (!same_key)        state_nxt = ST_SCAN;
        else if (stable_full) state_nxt = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!any_low && stable_full) state_nxt = ST_SCAN;
      end
      default: begin
        state_nxt = ST_SCAN;
      end
    endcase
  end

  always_comb begin
    row_n     = row_drive(row_idx);
    key_stb   = (state == ST_ACCEPT);
    state_dbg = state;
  end

  // Row index, latched column and the two counters that pace the FSM.
  // Leaving DEBOUNCE on a mismatch or leaving RELEASE moves on to the next row.
  always_ff @(posedge clk_o) begin
    if (!rst) begin
      row_idx    <= 2'd0;
      key_col    <= 2'd0;
      settle_cnt <= '0;
      stable_cnt <= '0;
      key_code   <= 4'h0;
    end else begin
      case (state)
        ST_SCAN: begin
          if (sample_now) begin
            settle_cnt <= '0;
            if (any_low) begin
              key_col    <= hit_col;
              stable_cnt <= '0;
            end else begin
              row_idx <= row_idx + 2'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (!same_key) begin
            row_idx    <= row_idx + 2'd1;
            settle_cnt <= '0;
            stable_cnt <= '0;
          end else if (stable_full) begin
            key_code   <= {row_idx, key_col};
            stable_cnt <= '0;
          end else begin
            stable_cnt <= stable_cnt + DW'(1);
          end
        end
        ST_ACCEPT: begin
          stable_cnt <= '0;
        end
        ST_RELEASE: begin
          if (any_low) begin
            stable_cnt <= '0;
          end else if (stable_full) begin
            stable_cnt <= '0;
            row_idx    <= row_idx + 2'd1;
            settle_cnt <= '0;
          end else begin
            stable_cnt <= stable_cnt + DW'(1);
          end
        end
        default: begin
          stable_cnt <= '0;
        end
      endcase
    end
  end

  logic        commit_stb;
  logic        ack_take;
  logic        commit_ok;
  logic [31:0] entry_shifted;

  btn_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_confirm (
    .clk_o (clk_o),
    .rst   (rst),
    .btn   (confirm_btn),
    .rise  (commit_stb)
  );

  // value/value_valid handshake: value_valid rises on a commit and stays high
  // until value_ack is seen high on a cycle where value_valid is high; value
  // itself is held afterwards. An ack on the commit cycle frees the slot
  // first, so the new commit lands and value_valid stays high.
  always_comb begin
    ack_take      = value_valid & value_ack;
    commit_ok     = commit_stb & (~value_valid | ack_take);
    entry_shifted = key_stb ? {entry[27:0], key_code} : entry;
  end

  always_ff @(posedge clk_o) begin
    if (!rst) begin
      entry       <= 32'h0;
      value       <= 32'h0;
      value_valid <= 1'b0;
    end else if (commit_ok) begin
      value       <= entry_shifted;
      entry       <= 32'h0;
      value_valid <= 1'b1;
    end else begin
      entry <= entry_shifted;
      if (ack_take) value_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_input.sv
// Bench for keypad_input: a behavioural keypad drives the columns from the row
// drive, and an event-level model tracks entry/value/value_valid.
module tb_keypad_input;
  import keypad_pkg::*;

  localparam int DEB = 8;

  logic        clk_o = 1'b0;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        confirm_btn;
  logic [31:0] entry;
  logic [31:0] value;
  logic        value_valid;
  logic        value_ack;
  logic [3:0]  key_code;
  logic        key_stb;
  logic [1:0]  state_dbg;

  logic        press_on;
  logic [1:0]  press_r;
  logic [1:0]  press_c;

  int          n_checks = 0;
  int          n_fail = 0;
  int          stb_seen = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  mon_k;
  logic [31:0] m_entry;
  logic [31:0] m_value;
  logic        m_valid;

  always #5 clk_o = ~clk_o;

  // A pressed switch shorts its column to its row only while that row is driven low.
  assign col_n = (press_on && !row_n[press_r]) ? ~(4'b0001 << press_c) : 4'hF;

  keypad_input dut (
    .clk_o       (clk_o),
    .rst         (rst),
    .row_n       (row_n),
    .col_n       (col_n),
    .confirm_btn (confirm_btn),
    .entry       (entry),
    .value       (value),
    .value_valid (value_valid),
    .value_ack   (value_ack),
    .key_code    (key_code),
    .key_stb     (key_stb),
    .state_dbg   (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk_o) begin
    if (key_stb === 1'b1) begin
      stb_seen++;
      check("stb_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_k = exp_q.pop_front();
        check("key_code", 32'(key_code), 32'(mon_k));
        m_entry = {m_entry[27:0], mon_k};
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_o);
  endtask

  task automatic press_key(input int code, input int hold, input int gap);
    press_r = 2'(code / 4);
    press_c = 2'(code % 4);
    exp_q.push_back(4'(code));
    press_on = 1'b1;
    cycles(hold);
    press_on = 1'b0;
    cycles(gap);
  endtask

  task automatic confirm_press(input int hold);
    confirm_btn = 1'b1;
    cycles(hold);
    confirm_btn = 1'b0;
    cycles(hold);
    if (!m_valid) begin
      m_value = m_entry;
      m_entry = 32'h0;
      m_valid = 1'b1;
    end
  endtask

  // Ack lands on the commit edge: two synchronizer stages plus DEB stable cycles.
  task automatic confirm_with_ack();
    confirm_btn = 1'b1;
    cycles(2 + DEB);
    value_ack = 1'b1;
    cycles(1);
    value_ack = 1'b0;
    cycles(10);
    confirm_btn = 1'b0;
    cycles(20);
    m_value = m_entry;
    m_entry = 32'h0;
    m_valid = 1'b1;
  endtask

  task automatic ack_pulse();
    value_ack = 1'b1;
    cycles(1);
    value_ack = 1'b0;
    cycles(2);
    m_valid = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".entry"}, entry, m_entry);
    check({tag, ".value"}, value, m_value);
    check({tag, ".valid"}, 32'(value_valid), 32'(m_valid));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int stb_before;
    logic found;
    rst = 1'b0;
    confirm_btn = 1'b0;
    value_ack = 1'b0;
    press_on = 1'b0;
    press_r = 2'd0;
    press_c = 2'd0;
    m_entry = 32'h0;
    m_value = 32'h0;
    m_valid = 1'b0;
    cycles(3);
    check("rst.row_n", 32'(row_n), 32'hE);
    check("rst.key_code", 32'(key_code), 32'h0);
    check("rst.key_stb", 32'(key_stb), 32'h0);
    check("rst.state", 32'(state_dbg), 32'(ST_SCAN));
    check_state("rst");
    rst = 1'b1;

    // Single key at row 2, col 1 held 20 cycles.
    stb_before = stb_seen;
    press_key(9, 20, 30);
    check("k9.stb_count", 32'(stb_seen - stb_before), 32'd1);
    check("k9.code", 32'(key_code), 32'h9);
    check("k9.entry_const", entry, 32'h9);
    check_state("k9");

    // Digits 1..9, oldest digit shifts out of the top.
    for (int k = 1; k <= 9; k++) press_key(k, 28, 22);
    check("seq.entry_const", entry, 32'h23456789);
    check_state("seq");

    // Short bounces never reach the stable count.
    stb_before = stb_seen;
    press_r = 2'd1;
    press_c = 2'd2;
    press_on = 1'b1;
    cycles(5);
    press_on = 1'b0;
    cycles(30);
    check("bounce5.state", 32'(state_dbg), 32'(ST_SCAN));
    for (int i = 0; i < 6; i++) begin
      press_on = 1'b1;
      cycles(3);
      press_on = 1'b0;
      cycles(2);
    end
    cycles(30);
    check("bounce_burst.state", 32'(state_dbg), 32'(ST_SCAN));
    check("bounce.stb_count", 32'(stb_seen - stb_before), 32'd0);
    check_state("bounce");

    // Commit, ack, then ABCD and a dropped second commit.
    confirm_press(20);
    check_state("commit1");
    ack_pulse();
    check_state("ack1");
    press_key(10, 28, 22);
    press_key(11, 28, 22);
    press_key(12, 28, 22);
    press_key(13, 28, 22);
    check("abcd.entry_const", entry, 32'hABCD);
    confirm_press(20);
    check("abcd.value_const", value, 32'h0000ABCD);
    check_state("abcd_commit");
    press_key(3, 28, 22);
    confirm_press(20);
    check("drop.value_const", value, 32'h0000ABCD);
    check_state("drop");

    // Ack coincident with a commit of 0x5.
    ack_pulse();
    confirm_press(20);
    press_key(5, 28, 22);
    check("five.entry_const", entry, 32'h5);
    confirm_with_ack();
    check("coinc.value_const", value, 32'h5);
    check_state("coinc");
    cycles(3);
    check("coinc.valid_hold", 32'(value_valid), 32'd1);

    // Randomized mix of presses, commits and acks.
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    press_key(int'($urandom_range(0, 15)), int'($urandom_range(28, 40)), int'($urandom_range(20, 30)));
        2:       confirm_press(20);
        default: ack_pulse();
      endcase
      check_state($sformatf("rand%0d", i));
    end

    // Reset mid-debounce while key 7 is held.
    press_r = 2'd1;
    press_c = 2'd3;
    press_on = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycles(1);
      if (state_dbg == 2'(ST_DEBOUNCE)) found = 1'b1;
    end
    check("k7.reach_debounce", 32'(found), 32'd1);
    cycles(2);
    stb_before = stb_seen;
    rst = 1'b0;
    cycles(1);
    rst = 1'b1;
    m_entry = 32'h0;
    m_value = 32'h0;
    m_valid = 1'b0;
    check("k7rst.row_n", 32'(row_n), 32'hE);
    check("k7rst.state", 32'(state_dbg), 32'(ST_SCAN));
    check("k7rst.key_stb", 32'(key_stb), 32'h0);
    check_state("k7rst");
    exp_q.push_back(4'h7);
    cycles(40);
    press_on = 1'b0;
    cycles(30);
    check("k7.stb_count", 32'(stb_seen - stb_before), 32'd1);
    check("k7.entry_const", entry, 32'h7);
    check_state("k7");
    check("pending_keys", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
